// File: rtl/qspi_mem_responder_if.sv
// rtl/qspi_mem_responder_if.sv - Quad-SPI host/target bus bundle
// Purpose : groups the QSPI pins shared by a host (master) and the memory
//           responder (slave).
// Signals : qspi_sclk   host serial clock, mode 0
//           qspi_cs_n   host chip select, active low
//           qspi_io_in  IO[3:0] driven by the host
//           qspi_io_out IO[3:0] driven by the responder
//           qspi_io_oe  per-bit responder output enable (1 = drive)
interface qspi_mem_responder_if;
  logic       qspi_sclk;
  logic       qspi_cs_n;
  logic [3:0] qspi_io_in;
  logic [3:0] qspi_io_out;
  logic [3:0] qspi_io_oe;

  modport master (
    output qspi_sclk, qspi_cs_n, qspi_io_in,
    input  qspi_io_out, qspi_io_oe
  );

  modport slave (
    input  qspi_sclk, qspi_cs_n, qspi_io_in,
    output qspi_io_out, qspi_io_oe
  );
endinterface

// File: rtl/qspi_mem_responder.sv
// rtl/qspi_mem_responder.sv - Quad-SPI memory target with flop-based byte array
// Purpose : oversamples host SCLK/CS_n/IO in the clk domain, decodes quad
//           read (0xEB) and write (0x38) transactions and serves them from an
//           internal MEM_DEPTH-byte array.
// Ports   : clk, rst_n (async, active low)
//           bus      qspi_mem_responder_if.slave (sclk, cs_n, io_in, io_out, io_oe)
//           busy     high while CS_n (synchronized) is low
//           wr_count bytes committed to memory, wraps 255->0
//           wp_n     active-low write protect, only with QSPI_RESP_WP_EN
// Option  : define QSPI_RESP_WP_EN to add wp_n; undefined, writes always allowed.
module qspi_mem_responder #(
  parameter int MEM_DEPTH    = 64,
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef QSPI_RESP_WP_EN
  input  logic       wp_n,
`endif
  qspi_mem_responder_if.slave bus,
  output logic       busy,
  output logic [7:0] wr_count
);

  localparam int         PTR_BITS   = $clog2(MEM_DEPTH);
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t              r_state;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic                r_cs_s1, r_cs_s2, r_cs_prev;
  logic [1:0]          r_settle;
  logic [3:0]          r_io_s1, r_io_s2;
  logic [7:0]          r_cnt;
  logic [3:0]          r_nib;
  logic                r_second;
  logic                r_is_write;
  logic [PTR_BITS-1:0] r_ptr;
  logic [3:0]          r_io_out;
  logic [3:0]          r_io_oe;
  logic                r_busy;
  logic [7:0]          r_wr_count;
  logic [7:0]          r_mem [MEM_DEPTH];

  logic                w_rise, w_fall, w_cs_fall, w_wp_ok;
  logic [7:0]          w_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_cs_prev   <= 1'b1;
      r_settle    <= 2'd0;
      r_io_s1     <= 4'h0;
      r_io_s2     <= 4'h0;
    end else begin
      r_sclk_s1   <= bus.qspi_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_cs_s1     <= bus.qspi_cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_prev   <= r_cs_s2;
      r_io_s1     <= bus.qspi_io_in;
      r_io_s2     <= r_io_s1;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

`ifdef QSPI_RESP_WP_EN
  logic r_wp_s1, r_wp_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp_s1 <= 1'b0;
      r_wp_s2 <= 1'b0;
    end else begin
      r_wp_s1 <= wp_n;
      r_wp_s2 <= r_wp_s1;
    end
  end
  assign w_wp_ok = r_wp_s2;
`else
  assign w_wp_ok = 1'b1;
`endif

  assign w_rise    = r_sclk_s2 & ~r_sclk_prev;
  assign w_fall    = ~r_sclk_s2 & r_sclk_prev;
  // The synchronizer resets to "deselected"; if CS_n is already low at reset
  // release, that reset value would look like a fresh falling edge. Only
  // accept a fall once the pipeline holds real pin history.
  assign w_cs_fall = r_cs_prev & ~r_cs_s2 & (r_settle == 2'd3);
  assign w_cmd     = {r_nib, r_io_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_nib      <= 4'h0;
      r_second   <= 1'b0;
      r_is_write <= 1'b0;
      r_ptr      <= '0;
      r_io_out   <= 4'h0;
      r_io_oe    <= 4'h0;
      r_busy     <= 1'b0;
      r_wr_count <= 8'd0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_busy <= ~r_cs_s2;
      // Deselect overrides everything, including an SCLK rise in the same
      // cycle; any half nibble or partial header is simply dropped.
      if (r_cs_s2) begin
        r_state  <= S_IDLE;
        r_io_oe  <= 4'h0;
        r_io_out <= 4'h0;
        r_second <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state  <= S_CMD;
              r_cnt    <= 8'd0;
              r_second <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_rise) begin
              if (!r_second) begin
                r_nib    <= r_io_s2;
                r_second <= 1'b1;
              end else begin
                r_second <= 1'b0;
                r_cnt    <= 8'd0;
                if (w_cmd == CMD_READ) begin
                  r_is_write <= 1'b0;
                  r_state    <= S_ADDR;
                end else if (w_cmd == CMD_WRITE && w_wp_ok) begin
                  r_is_write <= 1'b1;
                  r_state    <= S_ADDR;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              // Shifting through a PTR_BITS-wide register keeps only the
              // low address bits, which is exactly address mod MEM_DEPTH.
              r_ptr <= PTR_BITS'({r_ptr, r_io_s2});
              if (r_cnt == ADDR_LAST) begin
                r_cnt <= 8'd0;
                if (r_is_write)             r_state <= S_WDATA;
                else if (DUMMY_CYCLES == 0) r_state <= S_RDATA;
                else                        r_state <= S_DUMMY;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_DUMMY: begin
            if (w_rise) begin
              if (r_cnt == DUMMY_LAST) r_state <= S_RDATA;
              else                     r_cnt   <= r_cnt + 8'd1;
            end
          end
          S_RDATA: begin
            if (w_fall) begin
              r_io_oe <= 4'hF;
              if (!r_second) begin
                r_io_out <= r_mem[r_ptr][7:4];
                r_second <= 1'b1;
              end else begin
                r_io_out <= r_mem[r_ptr][3:0];
                r_second <= 1'b0;
                r_ptr    <= r_ptr + 1'b1;
              end
            end
          end
          S_WDATA: begin
            if (w_rise) begin
              if (!r_second) begin
                r_nib    <= r_io_s2;
                r_second <= 1'b1;
              end else begin
                r_mem[r_ptr] <= w_cmd;
                r_ptr        <= r_ptr + 1'b1;
                r_wr_count   <= r_wr_count + 8'd1;
                r_second     <= 1'b0;
              end
            end
          end
          default: begin
            r_io_oe <= 4'h0;
          end
        endcase
      end
    end
  end

  assign bus.qspi_io_out = r_io_out;
  assign bus.qspi_io_oe  = r_io_oe;
  assign busy            = r_busy;
  assign wr_count        = r_wr_count;

endmodule
